modulo_controlador_divisor: RTL
===============================

Name: modulo_controlador_divisor

Overview:
- Synchronous, run-time configurable clock-divider controller. Replaces the fixed ripple T-flip-flop chain with a single-clock counter.
- Produces a 50%-duty divided output plus a one-cycle tick enable for downstream logic.
- Sequences start/stop and glitch-free ratio changes through a small FSM.
- Sits between the board clock and every slow consumer (display scan, debouncers, timers).

Parameters:
- WIDTH, 20, counter width in bits.
- SEL_W, 5, width of the ratio-select exponent.
- DEFAULT_SEL, 18, exponent loaded at reset. Gives clk_div = F/524288.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  level; begin dividing when sampled high in IDLE.
- stop  in  1  level; return to IDLE when sampled high.
- sel  in  SEL_W  new exponent e; half-period = 2^e clk cycles.
- load  in  1  one-cycle request to apply sel.
- load_ack  out  1  one-cycle pulse when a loaded sel takes effect.
- busy  out  1  high in RUN or RELOAD.
- clk_div  out  1  registered divided clock, period 2^(e+1) cycles.
- tick  out  1  one-cycle pulse on each rising edge of clk_div.
- count  out  WIDTH  current counter value.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, counter=0, sel_reg=DEFAULT_SEL, pending=0. Outputs clk_div, tick, load_ack and busy all 0.
- Saturation: sel above WIDTH-1 saturates to WIDTH-1 on capture.
- Terminal count: tc = (counter == 2^sel_reg - 1).
- IDLE:
  - counter held at 0, clk_div=0.
  - start=1 and stop=0 -> RUN next cycle.
  - A load in IDLE updates sel_reg immediately, with load_ack the following cycle.
- RUN:
  - counter increments each cycle.
  - On tc: counter returns to 0 and clk_div toggles.
  - tick=1 in the cycle after clk_div goes 0->1, so ticks repeat every 2^(sel_reg+1) cycles.
  - First tick comes 2^sel_reg cycles after entering RUN.
- Load in RUN: sel is captured into sel_next, pending=1, state -> RELOAD.
- RELOAD:
  - Counting continues with the old sel_reg.
  - At the first tc where clk_div is about to go 1->0 (low-going boundary), sel_reg <= sel_next, counter=0, pending=0, load_ack pulses, state -> RUN.
  - This rule guarantees no runt pulse.
- Repeated loads while pending: sel_next is overwritten, so the latest value wins. Exactly one load_ack is issued.
- stop=1 in RUN or RELOAD:
  - -> IDLE next cycle; counter=0, clk_div=0, tick suppressed.
  - A pending load is applied to sel_reg with load_ack.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - load and stop in the same cycle: the load is applied (IDLE rule) and the FSM stops.
- sel=0: clk_div toggles every cycle (F/2) and tick fires every 2 cycles.
- busy = (state != IDLE).
- count is a direct register output.

Optional Feature:
- Macro: DIVISOR_TICK_COUNT_EN.
- When defined:
  - Adds output port tick_cnt [15:0], counting tick pulses.
  - Wraps 16'hFFFF -> 0.
  - Cleared by clr and on every entry to IDLE.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (divisor_pkg):
  - WIDTH, SEL_W and DEFAULT_SEL constants.
  - State enum IDLE=2'b00, RUN=2'b01, RELOAD=2'b10.
  - SAT_SEL function for clamping sel.
- One sub-module, modulo_contador_prescaler:
  - Counter with clear, enable and tc compare against 2^sel.
  - The FSM and output registers stay in the top.

Test Plan:
- Reset and default: clr low for 3 cycles, then high, start=1 -> first clk_div rise at cycle 262144 after RUN; tick every 524288 cycles.
- Fast ratio: in IDLE, load sel=2, then start -> clk_div toggles every 4 cycles; tick period 8; load_ack one cycle after load.
- Glitch-free reload: in RUN with sel=3, load sel=1 mid half-period -> old 8-cycle half-periods finish until the next falling boundary; then 2-cycle half-periods; one load_ack; no high or low pulse shorter than min(old, new) half-period.
- Overwrite: in RUN, load sel=4, then load sel=1 before it applies -> only sel=1 takes effect; exactly one load_ack.
- Stop and async reset: stop mid-RUN -> next cycle busy=0, clk_div=0, count=0; assert clr asynchronously mid-cycle -> outputs 0 immediately and sel_reg=18.
- Saturation and edge cases: sel=31 -> sel_reg=19; start with stop simultaneous -> stays IDLE. With DIVISOR_TICK_COUNT_EN, sel=0 and 10 ticks -> tick_cnt=10.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared constants, FSM state encoding and the exponent clamp for the
// clock-divider controller.
package divisor_pkg;

  localparam int DIV_WIDTH       = 20;
  localparam int DIV_SEL_W       = 5;
  localparam int DIV_DEFAULT_SEL = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    RELOAD = 2'b10
  } div_state_e;

  // Clamp a requested exponent so 2^e always fits in the counter.
  function automatic logic [DIV_SEL_W-1:0] SAT_SEL(input logic [DIV_SEL_W-1:0] s,
                                                   input int max_sel);
    if (int'(s) > max_sel) return DIV_SEL_W'(max_sel);
    return s;
  endfunction

endpackage

// File: rtl/modulo_contador_prescaler.sv
// Up-counter with synchronous clear and enable; wraps to 0 at the terminal
// count 2^sel - 1 and flags that cycle on tc.
module modulo_contador_prescaler
  import divisor_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int SEL_W = DIV_SEL_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] term;

  assign term  = (WIDTH'(1) << sel) - WIDTH'(1);
  assign tc    = (count_q == term);
  assign count = count_q;

  // Next count: clear wins, otherwise count up and wrap on terminal count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/modulo_controlador_divisor.sv
// Run-time configurable clock-divider controller: 50% duty clk_div with
// half-period 2^sel cycles, a tick on every clk_div rising edge, and ratio
// changes that only take effect on a falling boundary so no runt pulse is
// produced.
// Optional build macro DIVISOR_TICK_COUNT_EN adds a 16-bit tick counter
// output (tick_cnt), cleared on reset and on every return to IDLE.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | counter held at 0, clk_div low; loads apply immediately
// RUN    | dividing with sel_reg
// RELOAD | dividing with old sel_reg, sel_next waits for falling edge
module modulo_controlador_divisor
  import divisor_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH,
  parameter int SEL_W       = DIV_SEL_W,
  parameter int DEFAULT_SEL = DIV_DEFAULT_SEL
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  output logic             load_ack,
  output logic             busy,
  output logic             clk_div,
  output logic             tick,
`ifdef DIVISOR_TICK_COUNT_EN
  output logic [15:0]      tick_cnt,
`endif
  output logic [WIDTH-1:0] count
);

  div_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_reg_q, sel_reg_d;
  logic [SEL_W-1:0] sel_next_q, sel_next_d;
  logic             pending_q, pending_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             load_ack_q, load_ack_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] sel_sat;
  logic             tc;
  logic             cnt_clear;
  logic             cnt_en;

  assign sel_sat = SAT_SEL(sel, WIDTH - 1);

  modulo_contador_prescaler #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_prescaler (
    .clk   (clk),
    .clr   (clr),
    .clear (cnt_clear),
    .en    (cnt_en),
    .sel   (sel_reg_q),
    .count (count),
    .tc    (tc)
  );

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    sel_reg_d  = sel_reg_q;
    sel_next_d = sel_next_q;
    pending_d  = pending_q;
    clk_div_d  = clk_div_q;
    tick_d     = 1'b0;
    load_ack_d = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        clk_div_d = 1'b0;
        if (load) begin
          sel_reg_d  = sel_sat;
          load_ack_d = 1'b1;
        end
        if (start && !stop) state_d = RUN;
      end

      RUN, RELOAD: begin
        if (stop) begin
          // Stop beats everything; a load in flight still lands in sel_reg.
          state_d   = IDLE;
          cnt_clear = 1'b1;
          clk_div_d = 1'b0;
          pending_d = 1'b0;
          if (load) begin
            sel_reg_d  = sel_sat;
            load_ack_d = 1'b1;
          end else if (pending_q) begin
            sel_reg_d  = sel_next_q;
            load_ack_d = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
          if (tc) begin
            clk_div_d = !clk_div_q;
            tick_d    = !clk_div_q;
          end
          if (load) begin
            sel_next_d = sel_sat;
            pending_d  = 1'b1;
            state_d    = RELOAD;
          end
          // Swap ratio only where clk_div falls, so both phases stay whole.
          if (state_q == RELOAD && tc && clk_div_q) begin
            sel_reg_d  = load ? sel_sat : sel_next_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
            state_d    = RUN;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
        clk_div_d = 1'b0;
        pending_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      sel_reg_q  <= SEL_W'(DEFAULT_SEL);
      sel_next_q <= SEL_W'(DEFAULT_SEL);
      pending_q  <= 1'b0;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
      load_ack_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_reg_q  <= sel_reg_d;
      sel_next_q <= sel_next_d;
      pending_q  <= pending_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
      load_ack_q <= load_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign clk_div  = clk_div_q;
  assign tick     = tick_q;
  assign load_ack = load_ack_q;
  assign busy     = busy_q;

`ifdef DIVISOR_TICK_COUNT_EN
  logic [15:0] tick_cnt_q, tick_cnt_d;

  // Tick counter: cleared on each return to IDLE, wraps naturally at 16 bits.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (state_q != IDLE && state_d == IDLE) tick_cnt_d = '0;
    else if (tick_d)                        tick_cnt_d = tick_cnt_q + 16'd1;
  end

  // Tick counter register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) tick_cnt_q <= '0;
    else      tick_cnt_q <= tick_cnt_d;
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule
